// File: rtl/m00_axis_rd_pkg.sv
// Shared types and constants for the RAM-to-AXI4-Stream reader.
package m00_axis_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] DBG_IDLE  = 4'd0;
  localparam logic [3:0] DBG_RUN   = 4'd1;
  localparam logic [3:0] DBG_DRAIN = 4'd2;

  localparam int   FIFO_DEPTH = 4;
  localparam logic TSTRB_BIT  = 1'b1;

  function automatic logic [3:0] dbg_code(input state_e s);
    logic [3:0] code;
    case (s)
      ST_IDLE:  code = DBG_IDLE;
      ST_RUN:   code = DBG_RUN;
      ST_DRAIN: code = DBG_DRAIN;
      default:  code = DBG_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/m00_axis_ram_reader_fifo.sv
// 4-entry synchronous FIFO (axis_rd_fifo) holding RAM read data until the stream accepts it.
module axis_rd_fifo
  import m00_axis_rd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [2:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             do_push_s, do_pop_s;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = push && (count_q != 3'd4);
    do_pop_s  = pop && (count_q != 3'd0);
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 3'd0);

endmodule

// File: rtl/m00_axis_ram_reader.sv
// Streams len words from RAM address 0 onward as one AXI4-Stream packet.
// Optional debug word enabled by defining M00_AXIS_RD_DEBUG_EN.
module m00_axis_ram_reader
  import m00_axis_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    M_AXIS_ACLK,
  input  logic                    M_AXIS_ARESETN,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     len,
  output logic                    busy,
  output logic                    done,
  output logic                    RAM_REN,
  output logic [ADDR_WIDTH-1:0]   RAM_RADDR,
  input  logic [DATA_WIDTH-1:0]   RAM_RDATA,
  output logic                    M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  output logic [31:0]             debug_state
);

  localparam int              LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   ONE_L   = LW'(1);
  localparam logic [LW-1:0]   MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   rd_addr_q, rd_addr_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic            inflight_q, inflight_d;
  logic            done_q, done_d;

  logic [2:0]            fifo_count_s;
  logic                  fifo_empty_s;
  logic [DATA_WIDTH-1:0] fifo_rdata_s;
  logic [3:0]            occ_s;
  logic                  ren_s, tvalid_s, tlast_s, hs_s, last_hs_s;

  // Reads in flight are counted against the FIFO so every issued read has a slot.
  assign occ_s     = {1'b0, fifo_count_s} + {3'b000, inflight_q};
  assign ren_s     = (state_q == ST_RUN) && (occ_s < 4'd4);
  assign tvalid_s  = !fifo_empty_s;
  assign tlast_s   = tvalid_s && (beat_q == (len_q - ONE_L));
  assign hs_s      = tvalid_s && M_AXIS_TREADY;
  assign last_hs_s = hs_s && tlast_s;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_addr_d  = rd_addr_q;
    beat_d     = beat_q;
    inflight_d = ren_s;
    done_d     = last_hs_s;
    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d   = ST_RUN;
          len_d     = (len > MAX_LEN) ? MAX_LEN : len;
          rd_addr_d = '0;
          beat_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ren_s) begin
          rd_addr_d = rd_addr_q + ONE_L;
          if (rd_addr_q == (len_q - ONE_L)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          rd_addr_d = rd_addr_q;
        end
        if (hs_s) begin
          beat_d = beat_q + ONE_L;
        end else begin
          beat_d = beat_q;
        end
      end
      ST_DRAIN: begin
        if (hs_s) begin
          beat_d = beat_q + ONE_L;
        end else begin
          beat_d = beat_q;
        end
        if (last_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rd_addr_q  <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_addr_q  <= rd_addr_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  axis_rd_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .push  (inflight_q),
    .wdata (RAM_RDATA),
    .pop   (hs_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign RAM_REN       = ren_s;
  assign RAM_RADDR     = rd_addr_q[ADDR_WIDTH-1:0];
  assign M_AXIS_TVALID = tvalid_s;
  assign M_AXIS_TDATA  = fifo_rdata_s;
  assign M_AXIS_TLAST  = tlast_s;
  assign M_AXIS_TSTRB  = {(DATA_WIDTH/8){TSTRB_BIT}};

`ifdef M00_AXIS_RD_DEBUG_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic        xfer_act_q, xfer_act_d;

  // Transfer clock count spans first-beat through last-beat handshake inclusive.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    xfer_act_d = xfer_act_q;
    if (hs_s && (beat_q == '0)) begin
      xfer_cnt_d = 16'd1;
      xfer_act_d = !last_hs_s;
    end else if (xfer_act_q) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
      xfer_act_d = !last_hs_s;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
      xfer_act_d = 1'b0;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      xfer_cnt_q <= 16'd0;
      xfer_act_q <= 1'b0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      xfer_act_q <= xfer_act_d;
    end
  end

  assign debug_state = {dbg_code(state_q), {1'b0, fifo_count_s}, 8'h00, xfer_cnt_q};
`else
  assign debug_state = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_m00_axis_ram_reader.sv
// Directed self-checking bench for m00_axis_ram_reader with a 1-cycle-latency RAM model.
module tb_m00_axis_ram_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] len;
  logic        busy, done, ren, tvalid, tlast, tready;
  logic [9:0]  raddr;
  logic [31:0] rdata, tdata, debug_state;
  logic [3:0]  tstrb;

  logic [31:0] ram [1024];
  int          rd_cnt;
  logic [9:0]  last_raddr;
  int          checks;
  int          fails;
  int          rd_snap;

  m00_axis_ram_reader u_dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .start          (start),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .RAM_REN        (ren),
    .RAM_RADDR      (raddr),
    .RAM_RDATA      (rdata),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready),
    .debug_state    (debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren) begin
      rdata      <= ram[raddr];
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= raddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_pkt(input logic [10:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    chk("ren_c1", {31'd0, ren}, 32'd1);
    chk("raddr_c1", {22'd0, raddr}, 32'd0);
    chk("busy_c1", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_packet(input int n, input int stop_at, input bit toggle, input int inject_at);
    int          beats;
    int          cyc;
    int          first_v;
    logic        stall;
    logic [31:0] pdata;
    logic        plast;
    beats   = 0;
    cyc     = 0;
    first_v = -1;
    stall   = 1'b0;
    pdata   = 32'd0;
    plast   = 1'b0;
    while (beats < stop_at && cyc < 4 * n + 20) begin
      @(negedge clk);
      tready = toggle ? (cyc % 2 == 0) : 1'b1;
      start  = (cyc == inject_at);
      len    = 11'd5;
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("fifo_le4", {31'd0, (u_dut.fifo_count_s <= 3'd4)}, 32'd1);
      if (stall) begin
        chk("stall_valid", {31'd0, tvalid}, 32'd1);
        chk("stall_data", tdata, pdata);
        chk("stall_last", {31'd0, tlast}, {31'd0, plast});
      end
      if (tvalid) begin
        if (first_v < 0) first_v = cyc;
        chk("tdata", tdata, 32'hA5A5_0000 + beats);
        chk("tlast", {31'd0, tlast}, {31'd0, (beats == n - 1)});
        if (tready) beats++;
      end else begin
        chk("tlast_idle", {31'd0, tlast}, 32'd0);
      end
      stall = tvalid && !tready;
      pdata = tdata;
      plast = tlast;
      cyc++;
    end
    start = 1'b0;
    chk("beat_count", beats, stop_at);
    chk("first_valid_cycle", first_v, 32'd1);
  endtask

  task automatic finish_packet();
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("tvalid_after", {31'd0, tvalid}, 32'd0);
    @(negedge clk);
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rd_cnt = 0;
    last_raddr = 10'd0;
    rdata  = 32'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA5A5_0000 + i;
    rst_n  = 1'b0;
    start  = 1'b0;
    len    = 11'd0;
    tready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ren", {31'd0, ren}, 32'd0);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_raddr", {22'd0, raddr}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tstrb", {28'd0, tstrb}, 32'h0000_000F);
    chk("rst_debug", debug_state, 32'd0);
    rst_n = 1'b1;

    // len=4, TREADY=1
    rd_snap = rd_cnt;
    start_pkt(11'd4);
    run_packet(4, 4, 1'b0, -1);
    finish_packet();
    chk("len4_reads", rd_cnt - rd_snap, 32'd4);

    // len=1
    rd_snap = rd_cnt;
    start_pkt(11'd1);
    run_packet(1, 1, 1'b0, -1);
    finish_packet();
    chk("len1_reads", rd_cnt - rd_snap, 32'd1);

    // len=8 with TREADY toggling and a start injected mid-packet
    rd_snap = rd_cnt;
    start_pkt(11'd8);
    run_packet(8, 8, 1'b1, 3);
    tready = 1'b1;
    finish_packet();
    chk("len8_reads", rd_cnt - rd_snap, 32'd8);
    chk("len8_last_addr", {22'd0, last_raddr}, 32'd7);

    // len=0 ignored
    rd_snap = rd_cnt;
    @(negedge clk);
    start = 1'b1;
    len   = 11'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_ren", {31'd0, ren}, 32'd0);
      chk("len0_tvalid", {31'd0, tvalid}, 32'd0);
      chk("len0_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk("len0_reads", rd_cnt - rd_snap, 32'd0);

    // len=2000 clamps to 1024
    rd_snap = rd_cnt;
    start_pkt(11'd2000);
    run_packet(1024, 1024, 1'b0, -1);
    finish_packet();
    chk("clamp_reads", rd_cnt - rd_snap, 32'd1024);
    chk("clamp_last_addr", {22'd0, last_raddr}, 32'd1023);
`ifdef M00_AXIS_RD_DEBUG_EN
    chk("dbg_xfer_cnt", {16'd0, debug_state[15:0]}, 32'h0000_0400);
    chk("dbg_state", {28'd0, debug_state[31:28]}, 32'd0);
`endif

    // Reset after 5 beats of a 16-word packet
    start_pkt(11'd16);
    run_packet(16, 5, 1'b0, -1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ren", {31'd0, ren}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_snap = rd_cnt;
    start_pkt(11'd3);
    run_packet(3, 3, 1'b0, -1);
    finish_packet();
    chk("post_rst_reads", rd_cnt - rd_snap, 32'd3);
    chk("post_rst_last_addr", {22'd0, last_raddr}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/m00_axis_ram_reader.md
# m00_axis_ram_reader

AXI4-Stream master that streams a block of words from a local simple-dual-port RAM to the PS (AXI DMA S2MM channel). It is the transmit counterpart of the S00 stream-to-RAM writer and shares the same RAM geometry (1024 × 32). A start pulse with a length launches one packet: sequential RAM reads from address 0, buffered through a small FIFO to absorb the RAM read latency and TREADY backpressure, with TLAST on the final beat.

## Interface
- DATA_WIDTH, 32, RAM word and TDATA width
- ADDR_WIDTH, 10, RAM address width; max packet is 2**ADDR_WIDTH words
- M_AXIS_ACLK  in  1  sole clock
- M_AXIS_ARESETN  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  ADDR_WIDTH+1  packet length in words, sampled with start
- busy  out  1  high from the cycle after an accepted start until the last handshake
- done  out  1  one-cycle pulse in the cycle after the last-beat handshake
- RAM_REN  out  1  RAM read enable
- RAM_RADDR  out  ADDR_WIDTH  RAM read address
- RAM_RDATA  in  DATA_WIDTH  RAM read data, valid exactly one cycle after RAM_REN
- M_AXIS_TVALID  out  1  stream data valid
- M_AXIS_TDATA  out  DATA_WIDTH  stream data
- M_AXIS_TSTRB  out  DATA_WIDTH/8  constant all ones
- M_AXIS_TLAST  out  1  final beat of packet
- M_AXIS_TREADY  in  1  downstream ready
- debug_state  out  32  debug word (see Configuration)

## Operation
- States: IDLE, RUN (reads still to issue), DRAIN (all reads issued, FIFO emptying).
- IDLE -> RUN on start with len != 0; len = 0 is ignored (no busy, no done); len > 2**ADDR_WIDTH clamped to 2**ADDR_WIDTH.
- RUN: issue one read per cycle (RAM_REN=1, RAM_RADDR = next address, starting at 0, incrementing by 1) while fifo_count + reads_in_flight < 4. RUN -> DRAIN when the len-th read issues.
- Read data written into a 4-entry FIFO in the cycle RAM_RDATA is valid; FIFO head drives TDATA.
- Beat counter tracks handshakes; TLAST = TVALID && beat is len-1.
- DRAIN -> IDLE on the last-beat handshake (TVALID && TREADY && TLAST); done pulses next cycle.
- start while busy: ignored. Addresses never wrap within a packet.
- Reset (any time, including mid-packet): state IDLE, FIFO and counters cleared, reads in flight discarded.

## Timing
- Reset values: busy, done, RAM_REN, M_AXIS_TVALID, M_AXIS_TLAST = 0; RAM_RADDR, M_AXIS_TDATA, debug_state = 0; M_AXIS_TSTRB = all ones.
- start high in cycle c -> RAM_REN with address 0 in c+1 -> first TVALID in c+3.
- Sustained one beat per cycle while TREADY = 1.
- AXIS rules: TVALID never depends combinationally on TREADY; once asserted, TVALID, TDATA and TLAST hold until the handshake.
- FIFO occupancy never exceeds 4; no RAM read is issued without a guaranteed FIFO slot.

## Configuration
- M00_AXIS_RD_DEBUG_EN defined: debug_state[31:28] = state code (IDLE 0, RUN 1, DRAIN 2), [27:24] = FIFO count, [23:16] = 0, [15:0] = transfer clock count. The counter loads 1 on the first-beat handshake, increments every cycle through the last-beat handshake, then holds until the next first beat.
- Not defined: debug_state tied to 0; the counter logic is not built.

## Structure
- Package m00_axis_rd_pkg: state enum, debug state codes, FIFO depth constant (4), TSTRB constant.
- One sub-module, axis_rd_fifo: 4-entry synchronous FIFO with count output, same clock and reset as the top.

## Test plan
- RAM[i] = 0xA5A50000+i, len=4, TREADY=1 -> TDATA 0xA5A50000..0xA5A50003 on consecutive cycles, TLAST on 4th beat, first TVALID at c+3, done 1 cycle after last beat.
- len=1 -> single beat 0xA5A50000 with TLAST=1, busy for exactly that packet, done pulse.
- len=8, TREADY toggling 1,0,1,0 -> 8 beats in order, TDATA/TLAST stable during stalls, FIFO count ≤ 4, no lost or duplicated words.
- len=0 -> no activity; start during busy -> ignored; len=2000 -> 1024 beats, last RAM_RADDR = 1023, TLAST on beat 1024.
- Reset asserted after 5 beats of len=16 -> TVALID/busy drop immediately; then start with len=3 -> beats 0xA5A50000..02 from address 0.
- M00_AXIS_RD_DEBUG_EN defined, len=1024, TREADY=1 -> debug_state[15:0]=0x0400 after done, [31:28]=0.
